// File: rtl/vga_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter_if
// Wishbone classic host bus used by the VGA line/sprite memory arbiter.
//
// Signals (directions as seen by the arbiter):
//   wb_cyc_i, wb_stb_i, wb_we_i  host cycle, strobe, write enable
//   wb_sel_i  [3:0]              byte selects (writes only)
//   wb_addr_i [31:0]             byte address
//   wb_data_i [31:0]             host write data
//   wb_ack_o                     one-cycle acknowledge
//   wb_data_o [31:0]             registered read data
//
// Modports: master = host side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vga_mem_arbiter_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    output wb_ack_o, wb_data_o
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
// Shares one synchronous-read memory port between the display fetch engine
// and a Wishbone classic host. The display fetch always wins; the host
// access waits in a pending state until the port is free.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   wb (slave modport)     Wishbone host bus (see vga_mem_arbiter_if)
//   fetch_req_i/addr_i     display fetch, one word per asserted cycle
//   fetch_valid_o/data_o   fetch result, valid two cycles after request
//   vblank_i               blanking indicator from the timing generator
//   mem_*                  memory port (enable, write, byte mask, address,
//                          write data, read data one cycle after a read)
//
// Build option: define VGA_BLANK_WRITE_EN to restrict host grants to the
// vertical blanking interval (vblank_i=1). Without it vblank_i is ignored.
// ---------------------------------------------------------------------------
module vga_mem_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_mem_arbiter_if.slave  wb,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_valid_o,
  output logic [31:0]       fetch_data_o,
  input  logic              vblank_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {H_IDLE, H_PEND, H_READ, H_ACK} host_state_t;

  host_state_t       state_q;
  host_state_t       state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       data_q;
  logic              fetch_pend_q;
  logic              grant_ok;
  logic              accept;
  logic              host_issue;

  // The host may only take the port when the display side allows it; in the
  // blanking build that means during vertical blank only.
`ifdef VGA_BLANK_WRITE_EN
  assign grant_ok = vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign grant_ok      = 1'b1;
`endif

  // Only the word-address bits of the host byte address are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb.wb_addr_i[31:ADDR_W+2], wb.wb_addr_i[1:0]};

  assign accept     = (state_q == H_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign host_issue = (state_q == H_PEND) && wb.wb_cyc_i && !fetch_req_i && grant_ok;

  // The acknowledge follows wb_cyc_i in H_ACK, so a host that has already
  // abandoned the cycle never sees a stray ack.
  assign wb.wb_ack_o = (state_q == H_ACK) && wb.wb_cyc_i;

  // Host FSM state register; reset drops any in-flight host access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= H_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Host FSM next state. A pending access is abandoned if the host drops
  // wb_cyc_i before it reaches memory; once issued it always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      H_IDLE: if (accept) state_d = H_PEND;
      H_PEND: begin
        if (!wb.wb_cyc_i) begin
          state_d = H_IDLE;
        end else if (host_issue) begin
          state_d = we_q ? H_ACK : H_READ;
        end
      end
      H_READ:  state_d = H_ACK;
      H_ACK:   state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  // Capture the host request when it is accepted so the bus may change
  // while the access waits for the memory port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= 4'b0;
      data_q <= 32'b0;
    end else if (accept) begin
      addr_q <= wb.wb_addr_i[ADDR_W+1:2];
      we_q   <= wb.wb_we_i;
      sel_q  <= wb.wb_sel_i;
      data_q <= wb.wb_data_i;
    end
  end

  // Host read data arrives one cycle after issue, i.e. while in H_READ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb.wb_data_o <= 32'b0;
    end else if (state_q == H_READ) begin
      wb.wb_data_o <= mem_rdata_i;
    end
  end

  // Display fetch pipeline: remember that a fetch was issued, then register
  // the memory read data the following cycle together with its strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pend_q  <= 1'b0;
      fetch_valid_o <= 1'b0;
      fetch_data_o  <= 32'b0;
    end else begin
      fetch_pend_q  <= fetch_req_i;
      fetch_valid_o <= fetch_pend_q;
      if (fetch_pend_q) begin
        fetch_data_o <= mem_rdata_i;
      end
    end
  end

  // Memory port mux. The fetch request is forwarded unconditionally (even
  // during reset); the host only drives the port when it holds the grant.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wmask_o = 4'b0;
    mem_addr_o  = fetch_addr_i;
    mem_wdata_o = data_q;
    if (fetch_req_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = fetch_addr_i;
    end else if (host_issue) begin
      mem_en_o    = 1'b1;
      mem_we_o    = we_q;
      mem_wmask_o = we_q ? sel_q : 4'b0;
      mem_addr_o  = addr_q;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Self-checking bench for vga_mem_arbiter. A transaction-level model predicts
// the memory port, host ack/read data and fetch results every cycle; directed
// sequences pin the model with hand-computed values, then a randomized phase
// mixes host traffic with random fetches and blanking.
// ---------------------------------------------------------------------------
module tb_vga_mem_arbiter;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk;
  logic          reset_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          vblank;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  vga_mem_arbiter_if wb_if ();

  vga_mem_arbiter #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb           (wb_if),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (fetch_addr),
    .fetch_valid_o(fetch_valid),
    .fetch_data_o (fetch_data),
    .vblank_i     (vblank),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_wmask_o  (mem_wmask),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Counters owned by the model process, read by the main sequence.
  int ack_total = 0;
  int fv_total  = 0;

  // Commands from the main sequence to the fetch/vblank driver.
  int fetch_mode      = 0;
  int vblank_rand     = 0;
  int cmd_seq         = 0;
  int cmd_burst_len   = 0;
  int cmd_burst_addr  = 0;
  int cmd_vblank_low  = 0;

  logic [31:0] ram       [0:DEPTH-1];
  logic [31:0] model_mem [0:DEPTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'h5A5A0000 ^ 32'(i * 257);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memory: the port is sampled mid-cycle and applied just
  // after the next rising edge, so read data is valid through the cycle after
  // the access.
  initial begin : env_ram
    logic          s_en, s_we;
    logic [3:0]    s_mask;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
    mem_rdata = 32'b0;
    forever begin
      @(negedge clk);
      s_en = mem_en; s_we = mem_we; s_mask = mem_wmask; s_addr = mem_addr; s_wdata = mem_wdata;
      @(posedge clk);
      #1;
      if (s_en === 1'b1) begin
        if (s_we === 1'b1) begin
          for (int b = 0; b < 4; b++)
            if (s_mask[b]) ram[s_addr][8*b +: 8] = s_wdata[8*b +: 8];
        end else begin
          mem_rdata = ram[s_addr];
        end
      end
    end
  end

  // Fetch and vblank driver; updates two time units after each rising edge.
  initial begin : env_fetch
    int last_seq, burst_left, burst_addr, vlow_left;
    last_seq = 0; burst_left = 0; burst_addr = 0; vlow_left = 0;
    fetch_req = 1'b0; fetch_addr = '0; vblank = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (cmd_seq != last_seq) begin
        last_seq   = cmd_seq;
        burst_left = cmd_burst_len;
        burst_addr = cmd_burst_addr;
        vlow_left  = cmd_vblank_low;
      end
      case (fetch_mode)
        1: begin
          fetch_req  = ($urandom_range(0, 2) == 0);
          fetch_addr = AW'($urandom_range(0, DEPTH-1));
        end
        2: begin
          if (burst_left > 0) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(burst_addr);
            burst_addr++;
            burst_left--;
          end else begin
            fetch_req = 1'b0;
          end
        end
        3:       fetch_req = 1'b1;
        default: fetch_req = 1'b0;
      endcase
      if (vlow_left > 0) begin
        vblank = 1'b0;
        vlow_left--;
      end else if (vblank_rand != 0) begin
        vblank = ($urandom_range(0, 1) == 1);
      end else begin
        vblank = 1'b1;
      end
    end
  end

  // Reference model state: at most one outstanding host transaction, plus a
  // two-deep delay line of fetch results.
  bit          t_valid, t_issued, t_we;
  logic [3:0]  t_sel;
  logic [AW-1:0] t_addr;
  logic [31:0] t_data, t_rdata;
  int          t_acc, t_done;
  bit          st0_v, st1_v;
  logic [31:0] st0_d, st1_d;
  logic [31:0] exp_wb, exp_fd;

  // Compare process: every falling edge predicts this cycle's outputs from
  // the inputs and the model, compares, then advances the model.
  initial begin : model
    bit            e_en, e_we, e_ack, host_wr, was_free, grant;
    logic [3:0]    e_mask;
    logic [AW-1:0] e_addr;
    int            cyc_n;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
    t_valid = 0; t_issued = 0; st0_v = 0; st1_v = 0; exp_wb = 0; exp_fd = 0;
    st0_d = 0; st1_d = 0; cyc_n = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        t_valid = 0; t_issued = 0; st0_v = 0; st1_v = 0; exp_wb = 0; exp_fd = 0;
        checkOutput("rst_ack", {31'b0, wb_if.wb_ack_o}, 0);
        checkOutput("rst_wb_data", wb_if.wb_data_o, 0);
        checkOutput("rst_fetch_valid", {31'b0, fetch_valid}, 0);
        checkOutput("rst_fetch_data", fetch_data, 0);
        checkOutput("rst_mem_en", {31'b0, mem_en}, {31'b0, fetch_req});
        checkOutput("rst_mem_we", {31'b0, mem_we}, 0);
        checkOutput("rst_mem_wmask", {28'b0, mem_wmask}, 0);
        if (fetch_req) checkOutput("rst_fetch_addr", {23'b0, mem_addr}, {23'b0, fetch_addr});
      end else begin
        e_en = 0; e_we = 0; e_mask = 0; e_addr = '0; e_ack = 0; host_wr = 0;
        was_free = !t_valid;
`ifdef VGA_BLANK_WRITE_EN
        grant = vblank;
`else
        grant = 1'b1;
`endif
        if (fetch_req) begin
          e_en = 1; e_addr = fetch_addr;
        end
        if (t_valid && !t_issued && cyc_n > t_acc) begin
          if (!wb_if.wb_cyc_i) begin
            t_valid = 0;
          end else if (!fetch_req && grant) begin
            t_issued = 1;
            t_done   = cyc_n + (t_we ? 1 : 2);
            t_rdata  = model_mem[t_addr];
            e_en = 1; e_we = t_we; e_addr = t_addr;
            e_mask  = t_we ? t_sel : 4'b0;
            host_wr = t_we;
          end
        end
        if (t_valid && t_issued && cyc_n == t_done) begin
          e_ack = wb_if.wb_cyc_i;
          if (!t_we) exp_wb = t_rdata;
          t_valid = 0;
        end
        if (was_free && wb_if.wb_cyc_i && wb_if.wb_stb_i) begin
          t_valid = 1; t_issued = 0; t_acc = cyc_n;
          t_we   = wb_if.wb_we_i;
          t_sel  = wb_if.wb_sel_i;
          t_addr = wb_if.wb_addr_i[AW+1:2];
          t_data = wb_if.wb_data_i;
        end

        checkOutput("mem_en", {31'b0, mem_en}, {31'b0, e_en});
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        checkOutput("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_mask});
        if (e_en) checkOutput("mem_addr", {23'b0, mem_addr}, {23'b0, e_addr});
        if (host_wr) checkOutput("mem_wdata", mem_wdata, t_data);
        checkOutput("wb_ack", {31'b0, wb_if.wb_ack_o}, {31'b0, e_ack});
        checkOutput("wb_data", wb_if.wb_data_o, exp_wb);
        checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, st1_v});
        if (st1_v) exp_fd = st1_d;
        checkOutput("fetch_data", fetch_data, exp_fd);
        if (wb_if.wb_ack_o) ack_total++;
        if (fetch_valid) fv_total++;

        if (host_wr)
          for (int b = 0; b < 4; b++)
            if (t_sel[b]) model_mem[t_addr][8*b +: 8] = t_data[8*b +: 8];
        st1_v = st0_v; st1_d = st0_d;
        st0_v = fetch_req; st0_d = model_mem[fetch_addr];
      end
      cyc_n++;
    end
  end

  // One Wishbone classic transfer; starts and ends just after a rising edge.
  // lat counts cycles from the strobe cycle to the ack cycle.
  task automatic applyStimulus(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata, output int lat);
    bit got;
    got = 0; lat = 0; rdata = 32'b0;
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = we;
    wb_if.wb_sel_i = sel; wb_if.wb_addr_i = addr; wb_if.wb_data_i = data;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (wb_if.wb_ack_o) begin
        got = 1;
        rdata = wb_if.wb_data_o;
        break;
      end
      lat++;
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput("host_timeout", 0, 1);
    @(posedge clk);
    #1;
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    int lat, snap, snap_fv;
    reset_n = 1'b0;
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
    wb_if.wb_sel_i = 4'b0; wb_if.wb_addr_i = 32'b0; wb_if.wb_data_i = 32'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state_ack", {31'b0, wb_if.wb_ack_o}, 0);
    checkOutput("reset_state_fetch_valid", {31'b0, fetch_valid}, 0);
    checkOutput("reset_state_mem_en", {31'b0, mem_en}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Write then read back, followed by a partial-byte write.
    applyStimulus(1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
    checkOutput("write_latency", lat, 2);
    applyStimulus(0, 4'h0, 32'h10, 32'h0, rd, lat);
    checkOutput("read_latency", lat, 3);
    checkOutput("read_data_full", rd, 32'hDEADBEEF);
    applyStimulus(1, 4'h3, 32'h10, 32'h00001234, rd, lat);
    checkOutput("partial_write_latency", lat, 2);
    applyStimulus(0, 4'h0, 32'h10, 32'h0, rd, lat);
    checkOutput("read_data_partial", rd, 32'hDEAD1234);
    idleCycles(2);

    // Eight-word fetch burst starting in the same cycle as a host write.
    snap_fv = fv_total;
    fetch_mode = 2; cmd_burst_len = 8; cmd_burst_addr = 0; cmd_seq++;
    applyStimulus(1, 4'hF, 32'h1C, 32'h11223344, rd, lat);
    checkOutput("burst_host_latency", lat, 9);
    idleCycles(3);
    checkOutput("burst_valid_pulses", fv_total - snap_fv, 8);
    fetch_mode = 0;

    // Host strobe while the fetch holds the port, then cycle abandoned.
    snap = ack_total;
    fetch_mode = 3;
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b1;
    wb_if.wb_sel_i = 4'hF; wb_if.wb_addr_i = 32'h50; wb_if.wb_data_i = 32'hCAFEF00D;
    idleCycles(2);
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
    fetch_mode = 0;
    idleCycles(6);
    checkOutput("abort_no_ack", ack_total - snap, 0);
    checkOutput("abort_no_write", ram[20], init_word(20));
    applyStimulus(1, 4'hF, 32'h54, 32'h0BADCAFE, rd, lat);
    checkOutput("after_abort_latency", lat, 2);

    // Host write while vblank is low for twenty cycles.
    cmd_vblank_low = 20; cmd_burst_len = 0; cmd_seq++;
    applyStimulus(1, 4'hF, 32'h18, 32'h600DF00D, rd, lat);
`ifdef VGA_BLANK_WRITE_EN
    checkOutput("vblank_write_latency", lat, 21);
`else
    checkOutput("vblank_write_latency", lat, 2);
`endif
    cmd_vblank_low = 0;
    idleCycles(2);

    // Reset pulsed while a host read is in H_READ.
    snap = ack_total;
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0;
    wb_if.wb_sel_i = 4'h0; wb_if.wb_addr_i = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ack", {31'b0, wb_if.wb_ack_o}, 0);
    checkOutput("midreset_wb_data", wb_if.wb_data_o, 0);
    checkOutput("midreset_fetch_data", fetch_data, 0);
    checkOutput("midreset_mem_en", {31'b0, mem_en}, 0);
    @(posedge clk);
    #1;
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idleCycles(2);
    checkOutput("midreset_no_ack", ack_total - snap, 0);
    applyStimulus(0, 4'h0, 32'h10, 32'h0, rd, lat);
    checkOutput("post_reset_read_latency", lat, 3);
    checkOutput("post_reset_read_data", rd, 32'hDEAD1234);

    // Randomized mix of host traffic, fetches and blanking.
    fetch_mode = 1; vblank_rand = 1;
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      a = ($urandom() & ~32'h7FC) | (32'($urandom_range(0, 31)) << 2);
      applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), a, $urandom(), rd, lat);
      idleCycles($urandom_range(0, 2));
    end
    fetch_mode = 0; vblank_rand = 0;
    idleCycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
